// File: rtl/decode_stage_pkg.sv
// Shared types for the decode stage: raw fetch slot, decoded issue-queue entry, FSM states.
`default_nettype none

package decode_stage_pkg;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_LSU = 2'd1,
    FU_BRU = 2'd2
  } fu_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } decode_require_t;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    fu_t         fu;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
  } issue_queue_element_t;

  localparam issue_queue_element_t IQ_ELEM_ZERO = '0;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_stage_decoder.sv
// Single-slot combinational decoder: raw instruction word to issue-queue entry.
`default_nettype none

module decode_stage_decoder
  import decode_stage_pkg::*;
(
  input  decode_require_t      req,
  output issue_queue_element_t elem
);

  logic [31:0] ins;
  assign ins = req.instr;

  always_comb begin
    elem        = IQ_ELEM_ZERO;
    elem.valid  = 1'b1;
    elem.pc     = req.pc;
    elem.funct3 = ins[14:12];
    case (ins[6:0])
      OPC_OP: begin
        elem.fu  = FU_ALU;
        elem.rd  = ins[11:7];
        elem.rs1 = ins[19:15];
        elem.rs2 = ins[24:20];
      end
      OPC_OP_IMM: begin
        elem.fu  = FU_ALU;
        elem.rd  = ins[11:7];
        elem.rs1 = ins[19:15];
        elem.imm = sext12(ins[31:20]);
      end
      OPC_LOAD: begin
        elem.fu  = FU_LSU;
        elem.rd  = ins[11:7];
        elem.rs1 = ins[19:15];
        elem.imm = sext12(ins[31:20]);
      end
      OPC_STORE: begin
        elem.fu  = FU_LSU;
        elem.rs1 = ins[19:15];
        elem.rs2 = ins[24:20];
        elem.imm = sext12({ins[31:25], ins[11:7]});
      end
      OPC_BRANCH: begin
        elem.fu  = FU_BRU;
        elem.rs1 = ins[19:15];
        elem.rs2 = ins[24:20];
        elem.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      default: begin
        // Unknown opcode: entry still flows so the backend can raise the exception.
        elem.illegal = 1'b1;
        elem.funct3  = 3'd0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// Registered, flushable decode stage with compacting buffer and partial issue-queue push.
// Optional DECODE_PERF_EN adds saturating stall / partial-push counters.
`default_nettype none

module decode_stage
  import decode_stage_pkg::*;
#(
  parameter  int DECODE_WIDTH = 4,
  parameter  int IQ_CNT_W     = 3,
  localparam int CNT_W        = $clog2(DECODE_WIDTH + 1)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    flush,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [CNT_W-1:0]                        in_count,
  input  decode_require_t      [DECODE_WIDTH-1:0] decode_require,
  output issue_queue_element_t [DECODE_WIDTH-1:0] issue_queue_element,
  output logic [CNT_W-1:0]                        issue_queue_push_number,
  input  logic [IQ_CNT_W-1:0]                     iq_size_left,
  output logic [CNT_W-1:0]                        pending_count
`ifdef DECODE_PERF_EN
  ,
  output logic [31:0]                             perf_stall_cycles,
  output logic [31:0]                             perf_partial_pushes
`endif
);

  localparam int CMP_W  = (CNT_W > IQ_CNT_W) ? CNT_W : IQ_CNT_W;
  localparam int ELEM_W = $bits(issue_queue_element_t);

  issue_queue_element_t [DECODE_WIDTH-1:0] decoded;
  issue_queue_element_t [DECODE_WIDTH-1:0] buf_q;
  issue_queue_element_t [DECODE_WIDTH-1:0] buf_d;
  logic [CNT_W-1:0]                        pending_q;
  logic [CNT_W-1:0]                        pending_d;
  logic [CNT_W-1:0]                        push;
  logic [CMP_W-1:0]                        pend_ext;
  logic [CMP_W-1:0]                        left_ext;
  logic [2*DECODE_WIDTH*ELEM_W-1:0]        shift_src;
  logic [2*DECODE_WIDTH*ELEM_W-1:0]        shifted;
  logic                                    drain_all;
  logic                                    accept;
  state_t                                  state_q;
  state_t                                  state_d;

  for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_dec
    decode_stage_decoder u_dec (
      .req  (decode_require[g]),
      .elem (decoded[g])
    );
  end

  // Widen both operands so a large iq_size_left is never truncated into a small count.
  always_comb begin
    pend_ext  = CMP_W'(pending_q);
    left_ext  = CMP_W'(iq_size_left);
    push      = (left_ext < pend_ext) ? CNT_W'(left_ext) : pending_q;
    drain_all = (push == pending_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else if (accept) begin
      state_d = ST_HOLD;
    end else if ((state_q == ST_HOLD) && drain_all) begin
      state_d = ST_EMPTY;
    end
  end

  always_comb begin
    in_ready                = !flush && ((state_q == ST_EMPTY) || drain_all);
    issue_queue_push_number = push;
    pending_count           = pending_q;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      issue_queue_element[k] = (k < int'(pending_q)) ? buf_q[k] : IQ_ELEM_ZERO;
    end
  end

  assign accept = in_valid && in_ready && (in_count != '0);

  // Compaction: the buffer is viewed as one wide vector and shifted down by push entries.
  always_comb begin
    shift_src = {{(DECODE_WIDTH*ELEM_W){1'b0}}, buf_q};
    shifted   = shift_src >> (int'(push) * ELEM_W);
    buf_d     = buf_q;
    pending_d = pending_q;
    if (flush) begin
      buf_d     = '0;
      pending_d = '0;
    end else if (accept) begin
      for (int k = 0; k < DECODE_WIDTH; k++) begin
        buf_d[k] = (k < int'(in_count)) ? decoded[k] : IQ_ELEM_ZERO;
      end
      pending_d = in_count;
    end else begin
      buf_d     = shifted[DECODE_WIDTH*ELEM_W-1:0];
      pending_d = pending_q - push;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      buf_q     <= '0;
    end else begin
      pending_q <= pending_d;
      buf_q     <= buf_d;
    end
  end

`ifdef DECODE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles   <= '0;
      perf_partial_pushes <= '0;
    end else begin
      if (in_valid && !in_ready && (perf_stall_cycles != '1)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if ((push != '0) && (push < pending_q) && (perf_partial_pushes != '1)) begin
        perf_partial_pushes <= perf_partial_pushes + 32'd1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  a_in_count_legal : assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && in_ready) |-> (int'(in_count) <= DECODE_WIDTH));
`endif

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed vector table on the 4-wide build, random sweeps at widths 1 and 8.
`default_nettype none

module tb_decode_stage;
  import decode_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic decode_require_t rand_req(input int seq);
    decode_require_t r;
    logic [6:0] opc;
    case ($urandom_range(0, 5))
      0:       opc = OPC_OP;
      1:       opc = OPC_OP_IMM;
      2:       opc = OPC_LOAD;
      3:       opc = OPC_STORE;
      4:       opc = OPC_BRANCH;
      default: opc = 7'b1111111;
    endcase
    r.pc          = 32'(seq) * 32'd4;
    r.instr       = $urandom;
    r.instr[6:0]  = opc;
    return r;
  endfunction

  // Reference decode written from the instruction-format rules.
  function automatic issue_queue_element_t ref_decode(input decode_require_t r);
    issue_queue_element_t e;
    logic [31:0] i;
    i       = r.instr;
    e       = '0;
    e.valid = 1'b1;
    e.pc    = r.pc;
    if (i[6:0] == OPC_OP || i[6:0] == OPC_OP_IMM || i[6:0] == OPC_LOAD ||
        i[6:0] == OPC_STORE || i[6:0] == OPC_BRANCH) begin
      e.funct3 = i[14:12];
      e.fu     = (i[6:0] == OPC_LOAD || i[6:0] == OPC_STORE) ? FU_LSU :
                 (i[6:0] == OPC_BRANCH) ? FU_BRU : FU_ALU;
      if (i[6:0] != OPC_STORE && i[6:0] != OPC_BRANCH) e.rd = i[11:7];
      e.rs1 = i[19:15];
      if (i[6:0] == OPC_OP || i[6:0] == OPC_STORE || i[6:0] == OPC_BRANCH) e.rs2 = i[24:20];
      if (i[6:0] == OPC_OP_IMM || i[6:0] == OPC_LOAD) e.imm = 32'($signed(i[31:20]));
      if (i[6:0] == OPC_STORE) e.imm = 32'($signed({i[31:25], i[11:7]}));
      if (i[6:0] == OPC_BRANCH) e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
    end else begin
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  // ---------------- 4-wide directed build ----------------
  logic                            rst_n;
  logic                            flush;
  logic                            in_valid;
  logic                            in_ready;
  logic [2:0]                      in_count;
  decode_require_t      [3:0]      req;
  issue_queue_element_t [3:0]      elem;
  logic [2:0]                      push_num;
  logic [2:0]                      iq_size_left;
  logic [2:0]                      pending;
`ifdef DECODE_PERF_EN
  logic [31:0]                     perf_stall;
  logic [31:0]                     perf_partial;
`endif

  decode_stage #(.DECODE_WIDTH(4), .IQ_CNT_W(3)) u_dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .flush                   (flush),
    .in_valid                (in_valid),
    .in_ready                (in_ready),
    .in_count                (in_count),
    .decode_require          (req),
    .issue_queue_element     (elem),
    .issue_queue_push_number (push_num),
    .iq_size_left            (iq_size_left),
    .pending_count           (pending)
`ifdef DECODE_PERF_EN
    ,
    .perf_stall_cycles       (perf_stall),
    .perf_partial_pushes     (perf_partial)
`endif
  );

  typedef struct {
    logic       fl;
    logic       iv;
    logic [2:0] ic;
    logic [2:0] iq;
    int         exp_pend;
    int         exp_push;
    int         exp_ready;
  } vec_t;

  function automatic vec_t mk(input logic fl, input logic iv, input int ic, input int iq,
                              input int ep, input int eu, input int er);
    vec_t v;
    v.fl = fl; v.iv = iv; v.ic = 3'(ic); v.iq = 3'(iq);
    v.exp_pend = ep; v.exp_push = eu; v.exp_ready = er;
    return v;
  endfunction

  issue_queue_element_t mq[$];
  int seq_main  = 0;
  int stall_m   = 0;
  int partial_m = 0;

  // Called just after a falling edge; leaves the bench just after the next falling edge.
  task automatic step(input int idx, input vec_t v);
    int sz;
    int p;
    logic rdy;
    flush = v.fl; in_valid = v.iv; in_count = v.ic; iq_size_left = v.iq;
    for (int k = 0; k < 4; k++) req[k] = rand_req(seq_main + k);
    #1;
    sz  = mq.size();
    p   = (sz < int'(v.iq)) ? sz : int'(v.iq);
    rdy = !v.fl && (sz == p);
    check($sformatf("r%0d_pending", idx), 128'(pending), 128'(v.exp_pend));
    check($sformatf("r%0d_push", idx), 128'(push_num), 128'(v.exp_push));
    check($sformatf("r%0d_ready", idx), 128'(in_ready), 128'(v.exp_ready));
    for (int k = 0; k < 4; k++)
      check($sformatf("r%0d_slot%0d", idx, k), 128'(elem[k]),
            (k < sz) ? 128'(mq[k]) : 128'(0));
    if (v.iv && !rdy) stall_m++;
    if (p > 0 && p < sz) partial_m++;
    @(posedge clk);
    repeat (p) void'(mq.pop_front());
    if (v.fl) mq.delete();
    else if (v.iv && rdy && v.ic != 0) begin
      for (int k = 0; k < int'(v.ic); k++) mq.push_back(ref_decode(req[k]));
      seq_main += int'(v.ic);
    end
    @(negedge clk);
  endtask

  // ---------------- width sweep builds (1 and 8) ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
    localparam int W  = (gi == 0) ? 1 : 8;
    localparam int CW = $clog2(W + 1);
    logic                       s_rst_n;
    logic                       s_flush;
    logic                       s_iv;
    logic                       s_ready;
    logic [CW-1:0]              s_ic;
    logic [CW-1:0]              s_push;
    logic [CW-1:0]              s_pend;
    logic [2:0]                 s_iq;
    decode_require_t      [W-1:0] s_req;
    issue_queue_element_t [W-1:0] s_elem;
    logic                       done = 1'b0;
`ifdef DECODE_PERF_EN
    logic [31:0]                s_ps;
    logic [31:0]                s_pp;
`endif

    decode_stage #(.DECODE_WIDTH(W), .IQ_CNT_W(3)) u_dut (
      .clk                     (clk),
      .rst_n                   (s_rst_n),
      .flush                   (s_flush),
      .in_valid                (s_iv),
      .in_ready                (s_ready),
      .in_count                (s_ic),
      .decode_require          (s_req),
      .issue_queue_element     (s_elem),
      .issue_queue_push_number (s_push),
      .iq_size_left            (s_iq),
      .pending_count           (s_pend)
`ifdef DECODE_PERF_EN
      ,
      .perf_stall_cycles       (s_ps),
      .perf_partial_pushes     (s_pp)
`endif
    );

    initial begin
      issue_queue_element_t q[$];
      int seq;
      int sz;
      int p;
      int ic;
      int iq;
      logic fl;
      logic iv;
      logic rdy;
      seq = 0;
      s_rst_n = 1'b0; s_flush = 1'b0; s_iv = 1'b0; s_ic = '0; s_iq = '0; s_req = '0;
      repeat (2) @(negedge clk);
      s_rst_n = 1'b1;
      for (int c = 0; c < 300; c++) begin
        fl = ($urandom_range(0, 31) == 0);
        iv = ($urandom_range(0, 3) != 0);
        ic = $urandom_range(0, W);
        iq = $urandom_range(0, 7);
        s_flush = fl; s_iv = iv; s_ic = CW'(ic); s_iq = 3'(iq);
        for (int k = 0; k < W; k++) s_req[k] = rand_req(seq + k);
        #1;
        sz  = q.size();
        p   = (sz < iq) ? sz : iq;
        rdy = !fl && (sz == p);
        check($sformatf("w%0d_c%0d_pending", W, c), 128'(s_pend), 128'(sz));
        check($sformatf("w%0d_c%0d_push", W, c), 128'(s_push), 128'(p));
        check($sformatf("w%0d_c%0d_ready", W, c), 128'(s_ready), 128'(rdy));
        for (int k = 0; k < W; k++)
          check($sformatf("w%0d_c%0d_slot%0d", W, c, k), 128'(s_elem[k]),
                (k < sz) ? 128'(q[k]) : 128'(0));
        @(posedge clk);
        repeat (p) void'(q.pop_front());
        if (fl) q.delete();
        else if (iv && rdy && ic != 0) begin
          for (int k = 0; k < ic; k++) q.push_back(ref_decode(s_req[k]));
          seq += ic;
        end
        @(negedge clk);
      end
      done = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  vec_t tbl[25];

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_count = '0; iq_size_left = '0; req = '0;
    //                fl    iv    ic iq  pend push rdy
    tbl[0]  = mk(1'b0, 1'b0, 0, 7, 0, 0, 1);
    tbl[1]  = mk(1'b0, 1'b1, 4, 7, 0, 0, 1);
    tbl[2]  = mk(1'b0, 1'b1, 4, 7, 4, 4, 1);
    tbl[3]  = mk(1'b0, 1'b1, 2, 7, 4, 4, 1);
    tbl[4]  = mk(1'b0, 1'b0, 0, 7, 2, 2, 1);
    tbl[5]  = mk(1'b0, 1'b1, 4, 1, 0, 0, 1);
    tbl[6]  = mk(1'b0, 1'b1, 3, 1, 4, 1, 0);
    tbl[7]  = mk(1'b0, 1'b1, 3, 3, 3, 3, 1);
    tbl[8]  = mk(1'b0, 1'b1, 0, 0, 3, 0, 0);
    tbl[9]  = mk(1'b0, 1'b1, 0, 7, 3, 3, 1);
    tbl[10] = mk(1'b0, 1'b0, 0, 7, 0, 0, 1);
    tbl[11] = mk(1'b0, 1'b1, 4, 2, 0, 0, 1);
    tbl[12] = mk(1'b0, 1'b0, 0, 2, 4, 2, 0);
    tbl[13] = mk(1'b1, 1'b1, 3, 0, 2, 0, 0);
    tbl[14] = mk(1'b0, 1'b0, 0, 7, 0, 0, 1);
    tbl[15] = mk(1'b0, 1'b1, 2, 7, 0, 0, 1);
    for (int i = 16; i < 21; i++) tbl[i] = mk(1'b0, 1'b1, 1, 0, 2, 0, 0);
    tbl[21] = mk(1'b0, 1'b0, 0, 7, 2, 2, 1);
    tbl[22] = mk(1'b0, 1'b1, 4, 7, 0, 0, 1);
    tbl[23] = mk(1'b1, 1'b0, 0, 3, 4, 3, 0);
    tbl[24] = mk(1'b0, 1'b0, 0, 5, 0, 0, 1);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) step(i, tbl[i]);
`ifdef DECODE_PERF_EN
    check("perf_stall", 128'(perf_stall), 128'(stall_m));
    check("perf_partial", 128'(perf_partial), 128'(partial_m));
`endif

    // Asynchronous reset in the middle of a held group.
    step(100, mk(1'b0, 1'b1, 3, 0, 0, 0, 1));
    flush = 1'b0; in_valid = 1'b0; iq_size_left = 3'd0;
    #1;
    check("pre_reset_pending", 128'(pending), 128'(3));
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_pending", 128'(pending), 128'(0));
    check("areset_push", 128'(push_num), 128'(0));
    check("areset_ready", 128'(in_ready), 128'(1));
    check("areset_slot0", 128'(elem[0]), 128'(0));
`ifdef DECODE_PERF_EN
    check("areset_perf_stall", 128'(perf_stall), 128'(0));
    check("areset_perf_partial", 128'(perf_partial), 128'(0));
`endif
    mq.delete();
    stall_m = 0;
    partial_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(101, mk(1'b0, 1'b1, 1, 7, 0, 0, 1));
    step(102, mk(1'b0, 1'b0, 0, 7, 1, 1, 1));

    for (int t = 0; t < 5000 && !(g_sweep[0].done && g_sweep[1].done); t++) @(negedge clk);
    check("sweep_done", 128'({g_sweep[1].done, g_sweep[0].done}), 128'(2'b11));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
